add_stim_gen: RTL and testbench

//  Synthesizable stimulus source for the adder DUT stage: drives operand pairs (a,b) into the

---
 rtl/add_stim_gen.sv | 100 ++++++++++
 tb/tb_add_stim_gen.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/add_stim_gen.sv
// Stimulus source for the adder comparison stage: four directed corner vectors,
// then NUM_RANDOM LFSR vectors, over a valid/ready handshake.
module add_stim_gen #(
  parameter int          WIDTH      = 1,
  parameter int          NUM_RANDOM = 500,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] stim_a,
  output logic [WIDTH-1:0] stim_b,
  output logic             stim_valid,
  input  logic             stim_ready,
  output logic             busy,
  output logic             done,
  output logic [15:0]      vec_count
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] DIRECTED = 2'd1;
  localparam logic [1:0] RANDOM   = 2'd2;
  localparam logic [1:0] DONE     = 2'd3;

  localparam logic [15:0]      SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  // vec_count value while the final vector is on the bus
  localparam logic [15:0]      LAST_IDX = 16'(NUM_RANDOM + 3);
  localparam logic [WIDTH-1:0] MAX_VAL  = '1;

  logic [1:0]  state;
  logic [15:0] lfsr;
  logic [15:0] lfsr_step;
  logic [1:0]  dir_next;
  logic        xfer;

  assign xfer      = stim_valid & stim_ready;
  assign lfsr_step = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  // In DIRECTED, vec_count[1:0] is the index of the vector currently presented
  assign dir_next  = vec_count[1:0] + 2'd1;
  assign busy      = (state == DIRECTED) || (state == RANDOM);
  assign done      = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      stim_a     <= '0;
      stim_b     <= '0;
      stim_valid <= 1'b0;
      vec_count  <= '0;
      lfsr       <= SEED_EFF;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= DIRECTED;
            stim_valid <= 1'b1;
            stim_a     <= '0;
            stim_b     <= '0;
            vec_count  <= '0;
            lfsr       <= SEED_EFF;
          end
        end
        DIRECTED: begin
          if (xfer) begin
            vec_count <= vec_count + 16'd1;
            if (vec_count[1:0] == 2'd3) begin
              if (NUM_RANDOM > 0) begin
                // first random vector is the seed itself, unstepped
                state  <= RANDOM;
                stim_a <= lfsr[WIDTH-1:0];
                stim_b <= lfsr[2*WIDTH-1:WIDTH];
              end else begin
                state      <= DONE;
                stim_valid <= 1'b0;
              end
            end else begin
              stim_a <= dir_next[0] ? MAX_VAL : '0;
              stim_b <= dir_next[1] ? MAX_VAL : '0;
            end
          end
        end
        RANDOM: begin
          if (xfer) begin
            vec_count <= vec_count + 16'd1;
            lfsr      <= lfsr_step;
            if (vec_count == LAST_IDX) begin
              state      <= DONE;
              stim_valid <= 1'b0;
            end else begin
              stim_a <= lfsr_step[WIDTH-1:0];
              stim_b <= lfsr_step[2*WIDTH-1:WIDTH];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add_stim_gen.sv
// Scoreboard bench for add_stim_gen: expected vector streams are queued at each start
// and popped by per-instance monitors on every observed transfer.
module tb_add_stim_gen;

  localparam int W0 = 1;
  localparam int N0 = 500;
  localparam int W1 = 3;
  localparam int N1 = 0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          start0 = 1'b0;
  logic          ready0;
  logic [W0-1:0] a0, b0;
  logic          valid0, busy0, done0;
  logic [15:0]   cnt0;

  logic          start1 = 1'b0;
  logic          ready1 = 1'b1;
  logic [W1-1:0] a1, b1;
  logic          valid1, busy1, done1;
  logic [15:0]   cnt1;

  add_stim_gen #(.WIDTH(W0), .NUM_RANDOM(N0), .SEED(16'hACE1)) u0 (
    .clk(clk), .rst(rst), .start(start0), .stim_a(a0), .stim_b(b0),
    .stim_valid(valid0), .stim_ready(ready0), .busy(busy0), .done(done0),
    .vec_count(cnt0));

  // seed 0 must fall back to 16'hACE1; with no random vectors only directed ones appear
  add_stim_gen #(.WIDTH(W1), .NUM_RANDOM(N1), .SEED(16'h0000)) u1 (
    .clk(clk), .rst(rst), .start(start1), .stim_a(a1), .stim_b(b1),
    .stim_valid(valid1), .stim_ready(ready1), .busy(busy1), .done(done1),
    .vec_count(cnt1));

  int vectors = 0;
  int errors  = 0;

  logic [15:0] exp0_q[$];
  logic [15:0] exp1_q[$];
  int          xfer0 = 0;
  int          xfer1 = 0;
  bit          rand_ready = 1'b0;
  bit          stalled0 = 1'b0;
  logic [31:0] hold0;
  logic [15:0] e0, e1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference stream: directed corners, then seed-first LFSR values computed arithmetically
  task automatic push_seq(input int which, input int w, input int n);
    int maxv = (1 << w) - 1;
    int s = 16'hACE1;
    int fb;
    logic [15:0] v;
    for (int i = 0; i < 4; i++) begin
      v = {8'((i % 2) != 0 ? maxv : 0), 8'((i / 2) != 0 ? maxv : 0)};
      if (which == 0) exp0_q.push_back(v); else exp1_q.push_back(v);
    end
    for (int i = 0; i < n; i++) begin
      v = {8'(s % (1 << w)), 8'((s / (1 << w)) % (1 << w))};
      if (which == 0) exp0_q.push_back(v); else exp1_q.push_back(v);
      fb = ((s / 32768) + (s / 8192) + (s / 4096) + (s / 1024)) % 2;
      s  = (s * 2 + fb) % 65536;
    end
  endtask

  task automatic pulse_start(input int which);
    @(posedge clk); #1;
    if (which == 0) begin
      exp0_q.delete(); push_seq(0, W0, N0); xfer0 = 0; start0 = 1'b1;
    end else begin
      exp1_q.delete(); push_seq(1, W1, N1); xfer1 = 0; start1 = 1'b1;
    end
    @(posedge clk); #1;
    start0 = 1'b0;
    start1 = 1'b0;
    check(which == 0 ? "busy_after_start0" : "busy_after_start1", which == 0 ? busy0 : busy1, 1);
    check(which == 0 ? "done_clear0" : "done_clear1", which == 0 ? done0 : done1, 0);
  endtask

  task automatic wait_done(input int which, input int exp_cnt);
    int cyc = 0;
    while (((which == 0) ? done0 : done1) !== 1'b1 && cyc < 5000) begin
      @(posedge clk);
      cyc++;
    end
    repeat (2) @(negedge clk);
    if (which == 0) begin
      check("done0", done0, 1);
      check("final_count0", cnt0, exp_cnt);
      check("valid_after0", valid0, 0);
      check("busy_after0", busy0, 0);
      check("queue_empty0", exp0_q.size(), 0);
    end else begin
      check("done1", done1, 1);
      check("final_count1", cnt1, exp_cnt);
      check("valid_after1", valid1, 0);
      check("queue_empty1", exp1_q.size(), 0);
    end
  endtask

  always @(posedge clk) begin
    #1;
    ready0 = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  always @(negedge clk) begin
    if (rst) begin
      stalled0 = 1'b0;
    end else begin
      check("valid_busy0", valid0, busy0);
      if (stalled0)
        check("stall_hold0", {cnt0, 8'(a0), 8'(b0)}, hold0);
      if (valid0 && ready0) begin
        if (exp0_q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL extra0: got unexpected vector a=%0h b=%0h", a0, b0);
        end else begin
          e0 = exp0_q.pop_front();
          check("vec0", {cnt0, 8'(a0), 8'(b0)}, {16'(xfer0), e0});
        end
        xfer0++;
      end
      stalled0 = valid0 && !ready0;
      hold0    = {cnt0, 8'(a0), 8'(b0)};
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("valid_busy1", valid1, busy1);
      if (valid1 && ready1) begin
        if (exp1_q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL extra1: got unexpected vector a=%0h b=%0h", a1, b1);
        end else begin
          e1 = exp1_q.pop_front();
          check("vec1", {cnt1, 8'(a1), 8'(b1)}, {16'(xfer1), e1});
        end
        xfer1++;
      end
    end
  end

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid0", valid0, 0);
    check("rst_count0", cnt0, 0);
    check("rst_a0", a0, 0);
    check("rst_b0", b0, 0);
    check("rst_busy0", busy0, 0);
    check("rst_done0", done0, 0);
    check("rst_valid1", valid1, 0);
    @(negedge clk);
    rst = 1'b0;

    // full sequence with ready held high: no bubbles, 504 transfers
    rand_ready = 1'b0;
    pulse_start(0);
    wait_done(0, 4 + N0);

    // same stream under random backpressure, restarted from DONE
    rand_ready = 1'b1;
    pulse_start(0);
    wait_done(0, 4 + N0);

    // asynchronous reset after ten transfers
    pulse_start(0);
    begin
      int cyc = 0;
      while (xfer0 < 10 && cyc < 1000) begin
        @(posedge clk);
        cyc++;
      end
    end
    check("reached_ten", xfer0 >= 10, 1);
    #3 rst = 1'b1;
    #1;
    check("midrst_valid0", valid0, 0);
    check("midrst_count0", cnt0, 0);
    check("midrst_a0", a0, 0);
    check("midrst_b0", b0, 0);
    check("midrst_busy0", busy0, 0);
    exp0_q.delete();
    xfer0 = 0;
    @(negedge clk);
    rst = 1'b0;
    rand_ready = 1'b0;
    pulse_start(0);
    wait_done(0, 4 + N0);

    // no random vectors: DONE right after D3; a start while busy is ignored
    pulse_start(1);
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    wait_done(1, 4);
    pulse_start(1);
    wait_done(1, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors + 1);
    $fatal(1, "timeout");
  end

endmodule
